// File: rtl/pcont_refill_arb_if.sv
// Signal bundle between the refill arbiter, the I/D miss logic, the memory read port and the fill paths.
// The slave view is the arbiter; the master view is everything around it.
interface pcont_refill_arb_if #(
    parameter int IDX_W = 2
);
    logic             imiss;
    logic [31:0]      iaddr;
    logic             dmiss;
    logic [31:0]      daddr;
    logic             mreq;
    logic [31:0]      maddr;
    logic             mack;
    logic             mrdval;
    logic [31:0]      mrdata;
    logic             ifill_we;
    logic             dfill_we;
    logic [IDX_W-1:0] fill_idx;
    logic [31:0]      fill_data;
    logic             ival;
    logic             dval;
    logic             idone;
    logic             ddone;
    logic             busy;

    modport slave (
        input  imiss, iaddr, dmiss, daddr, mack, mrdval, mrdata,
        output mreq, maddr, ifill_we, dfill_we, fill_idx, fill_data,
        output ival, dval, idone, ddone, busy
    );

    modport master (
        output imiss, iaddr, dmiss, daddr, mack, mrdval, mrdata,
        input  mreq, maddr, ifill_we, dfill_we, fill_idx, fill_data,
        input  ival, dval, idone, ddone, busy
    );
endinterface

// File: rtl/pcont_refill_arb.sv
// Shares the single memory read port between I-cache and D-cache line refills:
// alternating-priority grant, request/ack, BEATS-word burst into the granted side, completion pulse.
module pcont_refill_arb #(
    parameter int BEATS = 4,
    parameter int IDX_W = 2
) (
    input  logic               sysclk,
    input  logic               reset_d2_r_n,
    pcont_refill_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEATS - 1);
    localparam logic [31:0]      LINE_MASK = ~(32'(BEATS * 4) - 32'd1);

    state_t           state;
    state_t           state_nxt;
    logic             sel_d;
    logic             last_i;
    logic [IDX_W-1:0] cnt;
    logic             grant_d;
    logic             beat;

    logic             mreq_r;
    logic [31:0]      maddr_r;
    logic             ifill_we_r;
    logic             dfill_we_r;
    logic [IDX_W-1:0] fill_idx_r;
    logic [31:0]      fill_data_r;
    logic             ival_r;
    logic             dval_r;
    logic             idone_r;
    logic             ddone_r;

    // On a tie the side that was not served last wins, so neither side can starve the other.
    assign grant_d = bus.dmiss && (!bus.imiss || last_i);
    assign beat    = (state == S_DATA) && bus.mrdval;

    always_ff @(posedge sysclk or negedge reset_d2_r_n) begin
        if (!reset_d2_r_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.imiss || bus.dmiss) state_nxt = S_REQ;
            S_REQ:   if (bus.mack) state_nxt = S_DATA;
            S_DATA:  if (beat && (cnt == LAST_IDX)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping and the memory request side.
    always_ff @(posedge sysclk or negedge reset_d2_r_n) begin
        if (!reset_d2_r_n) begin
            sel_d   <= 1'b0;
            last_i  <= 1'b1;
            mreq_r  <= 1'b0;
            maddr_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.imiss || bus.dmiss) begin
                        sel_d   <= grant_d;
                        last_i  <= !grant_d;
                        mreq_r  <= 1'b1;
                        maddr_r <= (grant_d ? bus.daddr : bus.iaddr) & LINE_MASK;
                    end
                end
                S_REQ: begin
                    if (bus.mack) begin
                        mreq_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fill side: every beat becomes a registered write one cycle later; strobes default low.
    always_ff @(posedge sysclk or negedge reset_d2_r_n) begin
        if (!reset_d2_r_n) begin
            cnt         <= '0;
            ifill_we_r  <= 1'b0;
            dfill_we_r  <= 1'b0;
            fill_idx_r  <= '0;
            fill_data_r <= '0;
            ival_r      <= 1'b0;
            dval_r      <= 1'b0;
            idone_r     <= 1'b0;
            ddone_r     <= 1'b0;
        end else begin
            ifill_we_r <= 1'b0;
            dfill_we_r <= 1'b0;
            ival_r     <= 1'b0;
            dval_r     <= 1'b0;
            idone_r    <= 1'b0;
            ddone_r    <= 1'b0;
            if (beat) begin
                cnt         <= cnt + IDX_W'(1);
                fill_idx_r  <= cnt;
                fill_data_r <= bus.mrdata;
                ifill_we_r  <= !sel_d;
                dfill_we_r  <= sel_d;
                ival_r      <= !sel_d && (cnt == '0);
                dval_r      <= sel_d && (cnt == '0);
                idone_r     <= !sel_d && (cnt == LAST_IDX);
                ddone_r     <= sel_d && (cnt == LAST_IDX);
            end
        end
    end

    assign bus.mreq      = mreq_r;
    assign bus.maddr     = maddr_r;
    assign bus.ifill_we  = ifill_we_r;
    assign bus.dfill_we  = dfill_we_r;
    assign bus.fill_idx  = fill_idx_r;
    assign bus.fill_data = fill_data_r;
    assign bus.ival      = ival_r;
    assign bus.dval      = dval_r;
    assign bus.idone     = idone_r;
    assign bus.ddone     = ddone_r;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_pcont_refill_arb.sv
// Bench for pcont_refill_arb: a cycle table for the basic D refill, hand sequences for
// arbitration order, bubbles, drops and reset, then random traffic against a transaction-level model.
module tb_pcont_refill_arb;

    localparam int          BEATS = 4;
    localparam int          IDX_W = 2;
    localparam logic [31:0] LMASK = ~(32'(BEATS * 4) - 32'd1);

    logic clk = 1'b0;
    logic rst_n;
    int   errs = 0;
    int   checks = 0;
    bit   last_i_m;

    always #5 clk = ~clk;

    pcont_refill_arb_if #(.IDX_W(IDX_W)) bus ();

    pcont_refill_arb #(.BEATS(BEATS), .IDX_W(IDX_W)) dut (
        .sysclk       (clk),
        .reset_d2_r_n (rst_n),
        .bus          (bus)
    );

    // flags: {mreq, ifill_we, dfill_we, ival, dval, idone, ddone, busy}
    typedef struct {
        logic        dmiss;
        logic        mack;
        logic        mrdval;
        logic [31:0] mrdata;
        logic [7:0]  eflags;
        logic [1:0]  eidx;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [7:0] flags();
        return {bus.mreq, bus.ifill_we, bus.dfill_we, bus.ival, bus.dval,
                bus.idone, bus.ddone, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_cyc(input string name, input logic [7:0] ef,
                           input logic [31:0] eidx, input logic [31:0] edata);
        chk({name, "_flags"}, 32'(flags()), 32'(ef));
        if (ef[6] || ef[5]) begin
            chk({name, "_idx"}, 32'(bus.fill_idx), eidx);
            chk({name, "_data"}, bus.fill_data, edata);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_flags"}, 32'(flags()), 32'd0);
        chk({name, "_maddr"}, bus.maddr, 32'd0);
        chk({name, "_idx"}, 32'(bus.fill_idx), 32'd0);
        chk({name, "_data"}, bus.fill_data, 32'd0);
    endtask

    // Model of the grant rule: D alone -> D, I alone -> I, both -> whoever was not served last.
    task automatic pick(output bit g);
        g = bus.dmiss && (!bus.imiss || last_i_m);
        last_i_m = !g;
    endtask

    // One full refill, starting in the S_IDLE cycle with the winning miss already raised.
    // pat gives MRDVAL for the first plen data-phase cycles, 1 afterwards.
    task automatic txn(input bit sd, input logic [31:0] addr, input int mwait, input bit noise,
                       input logic [31:0] pat, input int plen, input int drop_at);
        int          k = 0;
        int          c = 0;
        int          nwe = 0;
        bit          v;
        logic [31:0] d;
        logic [7:0]  ef;
        tick();
        chk("req_mreq", 32'(bus.mreq), 32'd1);
        chk("req_maddr", bus.maddr, addr & LMASK);
        for (int w = 0; w < mwait; w++) begin
            bus.mrdval = noise;
            bus.mrdata = $urandom;
            tick();
            exp_cyc("req_wait", 8'b1000_0001, 0, 0);
            chk("req_maddr_hold", bus.maddr, addr & LMASK);
        end
        bus.mrdval = noise;
        bus.mack = 1'b1;
        tick();
        bus.mack = 1'b0;
        exp_cyc("ack", 8'b0000_0001, 0, 0);
        while (k < BEATS) begin
            v = (c < plen) ? pat[c] : 1'b1;
            c++;
            d = $urandom;
            bus.mrdval = v;
            bus.mrdata = d;
            tick();
            if (v) begin
                ef = {1'b0, !sd, sd, !sd && (k == 0), sd && (k == 0),
                      !sd && (k == BEATS - 1), sd && (k == BEATS - 1), 1'b1};
                exp_cyc("beat", ef, 32'(k), d);
                k++;
            end else begin
                exp_cyc("bubble", 8'b0000_0001, 0, 0);
            end
            nwe += int'(sd ? bus.dfill_we : bus.ifill_we);
            if (k == drop_at) begin
                if (sd) bus.dmiss = 1'b0; else bus.imiss = 1'b0;
            end
        end
        bus.mrdval = 1'b0;
        if (sd) bus.dmiss = 1'b0; else bus.imiss = 1'b0;
        tick();
        exp_cyc("idle_after", 8'b0000_0000, 0, 0);
        chk("we_count", 32'(nwe), 32'(BEATS));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         8'b1000_0001, 2'd0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0,         8'b1000_0001, 2'd0, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,         8'b1000_0001, 2'd0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,         8'b0000_0001, 2'd0, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hA0A0_0000, 8'b0010_1001, 2'd0, 32'hA0A0_0000};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hA1A1_1111, 8'b0010_0001, 2'd1, 32'hA1A1_1111};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'hA2A2_2222, 8'b0010_0001, 2'd2, 32'hA2A2_2222};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'hA3A3_3333, 8'b0010_0011, 2'd3, 32'hA3A3_3333};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         8'b0000_0000, 2'd0, 32'h0};

        rst_n = 1'b0;
        bus.imiss = 1'b0; bus.iaddr = 32'h0;
        bus.dmiss = 1'b0; bus.daddr = 32'h1000_0014;
        bus.mack = 1'b0; bus.mrdval = 1'b0; bus.mrdata = 32'h0;
        last_i_m = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Basic D refill, cycle by cycle.
        foreach (tbl[i]) begin
            bus.dmiss  = tbl[i].dmiss;
            bus.mack   = tbl[i].mack;
            bus.mrdval = tbl[i].mrdval;
            bus.mrdata = tbl[i].mrdata;
            tick();
            exp_cyc($sformatf("tbl%0d", i), tbl[i].eflags, 32'(tbl[i].eidx), tbl[i].edata);
            chk($sformatf("tbl%0d_maddr", i), bus.maddr, 32'h1000_0010);
        end
        bus.mack = 1'b0; bus.mrdval = 1'b0;
        last_i_m = 1'b0;

        // Both misses held across reset release: D, then I, then D again after re-raise.
        #2 rst_n = 1'b0;
        bus.imiss = 1'b1; bus.iaddr = 32'h0000_4008;
        bus.dmiss = 1'b1; bus.daddr = 32'h8000_0030;
        tick();
        chk_reset("reset2");
        rst_n = 1'b1;
        last_i_m = 1'b1;
        pick(g); chk("order1_is_d", 32'(g), 32'd1);
        txn(g, g ? bus.daddr : bus.iaddr, 1, 1'b0, 0, 0, -1);
        pick(g); chk("order2_is_i", 32'(g), 32'd0);
        txn(g, g ? bus.daddr : bus.iaddr, 0, 1'b0, 0, 0, -1);
        bus.imiss = 1'b1; bus.dmiss = 1'b1;
        pick(g); chk("order3_is_d", 32'(g), 32'd1);
        txn(g, g ? bus.daddr : bus.iaddr, 2, 1'b0, 0, 0, -1);
        pick(g);
        txn(g, g ? bus.daddr : bus.iaddr, 0, 1'b0, 0, 0, -1);

        // I refill with MRDVAL bubbles 1,0,0,1,1,0,1.
        bus.imiss = 1'b1; bus.iaddr = 32'h0001_237C;
        pick(g);
        txn(g, bus.iaddr, 1, 1'b0, 32'h59, 7, -1);

        // I miss dropped after the first beat.
        bus.imiss = 1'b1; bus.iaddr = 32'h0002_0004;
        pick(g);
        txn(g, bus.iaddr, 0, 1'b0, 0, 0, 1);

        // MRDVAL asserted while still waiting for MACK.
        bus.dmiss = 1'b1; bus.daddr = 32'h0003_003F;
        pick(g);
        txn(g, bus.daddr, 3, 1'b1, 0, 0, -1);

        // Asynchronous reset after two D beats, then a fresh refill of the same line.
        bus.dmiss = 1'b1; bus.daddr = 32'h2345_678C;
        pick(g);
        tick();
        chk("rst4_mreq", 32'(bus.mreq), 32'd1);
        bus.mack = 1'b1;
        tick();
        bus.mack = 1'b0;
        bus.mrdval = 1'b1; bus.mrdata = 32'h0000_0011;
        tick();
        exp_cyc("rst4_b0", 8'b0010_1001, 0, 32'h0000_0011);
        bus.mrdata = 32'h0000_0022;
        tick();
        exp_cyc("rst4_b1", 8'b0010_0001, 1, 32'h0000_0022);
        #2 rst_n = 1'b0;
        bus.mrdval = 1'b0;
        #1 chk_reset("rst4_async");
        tick();
        rst_n = 1'b1;
        last_i_m = 1'b1;
        pick(g);
        txn(g, 32'h2345_678C, 0, 1'b0, 0, 0, -1);

        // Random traffic; losers stay pending across transactions.
        for (int n = 0; n < 40; n++) begin
            if (!bus.imiss && ($urandom_range(0, 1) == 1)) begin
                bus.iaddr = $urandom; bus.imiss = 1'b1;
            end
            if (!bus.dmiss && ($urandom_range(0, 1) == 1)) begin
                bus.daddr = $urandom; bus.dmiss = 1'b1;
            end
            if (!bus.imiss && !bus.dmiss) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.daddr = $urandom; bus.dmiss = 1'b1;
                end else begin
                    bus.iaddr = $urandom; bus.imiss = 1'b1;
                end
            end
            pick(g);
            txn(g, g ? bus.daddr : bus.iaddr, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom, $urandom_range(0, 8), $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
